rom_stream_tx: RTL

- Transmitter end of the ROM download byte stream (ioctl_downl / ioctl_wr / ioctl_data / ioctl_wait) consumed by the ROM loader.
- Serializes a board-config byte, then a list of region records, each as region byte, 24-bit big-endian size, then payload bytes.
- Payload bytes are fetched from a byte-source port.
- Used for in-core reloads and for driving the loader in simulation without the host bridge.

---
 rtl/rom_stream_tx.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/rom_stream_tx.sv
// ROM download stream source: board cfg byte, then region records over ioctl.
// Define ROM_STREAM_TX_AUTOINC_EN to send 0xFF for consecutive region indices.
module rom_stream_tx #(
  parameter int MAX_REGIONS = 16,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  board_cfg_in,
  input  logic [4:0]  num_regions,
  output logic [3:0]  desc_idx,
  input  logic [3:0]  desc_region,
  input  logic [23:0] desc_size,
  output logic        src_req,
  output logic [3:0]  src_region,
  output logic [23:0] src_offset,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        ioctl_downl,
  output logic        ioctl_wr,
  output logic [7:0]  ioctl_data,
  input  logic        ioctl_wait,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CFG   = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DESC  = 3'd3;
  localparam logic [2:0] S_DLAT  = 3'd4;
  localparam logic [2:0] S_FETCH = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam logic [1:0] K_CFG  = 2'd0;
  localparam logic [1:0] K_HDR  = 2'd1;
  localparam logic [1:0] K_DATA = 2'd2;

  logic [2:0]  r_state;
  logic [1:0]  r_kind;
  logic [1:0]  r_hdr;
  logic [3:0]  r_gap;
  logic [4:0]  r_nreg;
  logic [4:0]  r_idx;
  logic [23:0] r_size;
  logic [3:0]  r_desc_idx;
  logic        r_src_req;
  logic [3:0]  r_src_region;
  logic [23:0] r_src_offset;
  logic        r_downl;
  logic        r_wr;
  logic [7:0]  r_data;
  logic        r_busy;
  logic        r_done;

  logic        w_gap_done;
  logic        w_last;
  logic [4:0]  w_idx_nx;
  logic [7:0]  w_size_byte;
  logic [7:0]  w_rbyte;
  logic [4:0]  w_nreg_in;

  assign desc_idx    = r_desc_idx;
  assign src_req     = r_src_req;
  assign src_region  = r_src_region;
  assign src_offset  = r_src_offset;
  assign ioctl_downl = r_downl;
  assign ioctl_wr    = r_wr;
  assign ioctl_data  = r_data;
  assign busy        = r_busy;
  assign done        = r_done;

  assign w_gap_done = (r_gap == 4'(GAP_CYCLES));
  assign w_idx_nx   = r_idx + 5'd1;
  assign w_nreg_in  = (num_regions > 5'(MAX_REGIONS)) ?
                      5'(MAX_REGIONS) : num_regions;

  // Region ends after its header when empty, else after byte size-1.
  assign w_last = (r_kind == K_HDR) ? (r_size == 24'd0) :
                  (r_src_offset == r_size - 24'd1);

  always_comb begin
    w_size_byte = r_size[7:0];
    unique case (r_hdr)
      2'd0:    w_size_byte = r_size[23:16];
      2'd1:    w_size_byte = r_size[15:8];
      default: w_size_byte = r_size[7:0];
    endcase
  end

`ifdef ROM_STREAM_TX_AUTOINC_EN
  logic [3:0] r_prev;
  logic       r_first;

  assign w_rbyte = (!r_first && desc_region == r_prev + 4'd1) ?
                   8'hFF : {4'h0, desc_region};

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_prev  <= 4'd0;
      r_first <= 1'b1;
    end else if (r_state == S_IDLE && start) begin
      r_first <= 1'b1;
    end else if (r_state == S_DLAT) begin
      r_prev  <= desc_region;
      r_first <= 1'b0;
    end
  end
`else
  assign w_rbyte = {4'h0, desc_region};
`endif

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_kind       <= K_CFG;
      r_hdr        <= 2'd0;
      r_gap        <= 4'd0;
      r_nreg       <= 5'd0;
      r_idx        <= 5'd0;
      r_size       <= 24'd0;
      r_desc_idx   <= 4'd0;
      r_src_req    <= 1'b0;
      r_src_region <= 4'd0;
      r_src_offset <= 24'd0;
      r_downl      <= 1'b0;
      r_wr         <= 1'b0;
      r_data       <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_nreg  <= w_nreg_in;
            r_idx   <= 5'd0;
            r_busy  <= 1'b1;
            r_downl <= 1'b1;
            r_data  <= board_cfg_in;
            r_state <= S_CFG;
          end
        end
        S_CFG: begin
          r_wr    <= 1'b1;
          r_kind  <= K_CFG;
          r_gap   <= 4'd0;
          r_state <= S_GAP;
        end
        S_GAP: begin
          r_wr <= 1'b0;
          if (!w_gap_done) begin
            r_gap <= r_gap + 4'd1;
          end else if (!ioctl_wait) begin
            // Size bytes follow the region byte back to back.
            if (r_kind == K_HDR && r_hdr != 2'd3) begin
              r_hdr  <= r_hdr + 2'd1;
              r_wr   <= 1'b1;
              r_data <= w_size_byte;
              r_gap  <= 4'd0;
            end else if (r_kind == K_CFG) begin
              if (r_nreg == 5'd0) begin
                r_state <= S_FIN;
              end else begin
                r_desc_idx <= 4'd0;
                r_state    <= S_DESC;
              end
            end else if (!w_last) begin
              r_src_req    <= 1'b1;
              r_src_offset <= (r_kind == K_HDR) ?
                              24'd0 : r_src_offset + 24'd1;
              r_state      <= S_FETCH;
            end else begin
              r_idx <= w_idx_nx;
              if (w_idx_nx == r_nreg) begin
                r_state <= S_FIN;
              end else begin
                r_desc_idx <= w_idx_nx[3:0];
                r_state    <= S_DESC;
              end
            end
          end
        end
        S_DESC: begin
          r_state <= S_DLAT;
        end
        S_DLAT: begin
          r_size       <= desc_size;
          r_src_region <= desc_region;
          r_data       <= w_rbyte;
          r_wr         <= 1'b1;
          r_kind       <= K_HDR;
          r_hdr        <= 2'd0;
          r_gap        <= 4'd0;
          r_state      <= S_GAP;
        end
        S_FETCH: begin
          if (src_valid) begin
            r_src_req <= 1'b0;
            r_data    <= src_data;
            r_wr      <= 1'b1;
            r_kind    <= K_DATA;
            r_gap     <= 4'd0;
            r_state   <= S_GAP;
          end
        end
        S_FIN: begin
          if (!ioctl_wait) begin
            r_downl <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
